aes_iter_ctrl: RTL and testbench
================================

# aes_iter_ctrl

Sequencer for an area-reduced, iterative AES-128 encryptor. It runs one shared key-expansion unit and one shared round unit ten times. It owns the running state, round key, round counter and rcon. Upstream sees a start/ready/done handshake; downstream it drives the round and key units, which are free-running registered pipelines with no valid signals.

## Interface
- KX_LAT, 1, register latency of the key-expansion unit in cycles; legal range 1..15.
- RND_LAT, 2, register latency of the round unit in cycles; the same value applies to normal and final rounds; legal range 1..15.

- clk  in  1  sole clock; all flops update on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to encrypt; sampled only while ready=1.
- key  in  128  cipher key K0; captured on the accepting edge.
- pt  in  128  plaintext; captured on the accepting edge.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse; ct is valid.
- ct  out  128  ciphertext; holds its value until the next done.
- kx_key_o  out  128  previous round key K(r-1) fed to the key unit.
- kx_rcon_o  out  8  rcon for round r.
- kx_key_i  in  128  K(r) returned by the key unit KX_LAT cycles after its inputs are presented.
- rnd_state_o  out  128  state fed to the round unit.
- rnd_key_o  out  128  round key K(r).
- rnd_final_o  out  1  high for round 10, which selects the final round (no MixColumns).
- rnd_state_i  in  128  round result, valid RND_LAT cycles after its inputs are presented.

## Operation
- Registers: st[127:0], rk[127:0], rcon[7:0], rnd[3:0] (1..10), cnt[3:0], fsm in {IDLE, KEY, RND}, ct, done.
- IDLE, start=1 (accept edge):
  - st <= pt ^ key (initial AddRoundKey), rk <= key, rcon <= 8'h01, rnd <= 1, cnt <= 0.
  - Go to KEY.
- KEY:
  - kx_key_o = rk, kx_rcon_o = rcon; both are held constant for the whole state.
  - cnt increments each cycle.
  - At the edge where cnt==KX_LAT: rk <= kx_key_i, rcon <= xtime(rcon), cnt <= 0, go to RND.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00). The sequence is 01,02,04,08,10,20,40,80,1b,36.
- RND:
  - rnd_state_o = st, rnd_key_o = rk, rnd_final_o = (rnd==10); all held constant.
  - cnt increments each cycle.
  - At the edge where cnt==KX... correction: at the edge where cnt==RND_LAT, st <= rnd_state_i and cnt <= 0.
  - If rnd<10: rnd <= rnd+1, go to KEY.
  - Otherwise: ct <= rnd_state_i, done <= 1, go to IDLE.
- All kx_* and rnd_* outputs come directly from registers (no combinational path from inputs). Outside their active state they keep their last register values.
- start, key and pt are ignored outside IDLE. Changing key or pt after acceptance has no effect.
- Reset:
  - rst=1 at any edge forces IDLE and clears every register (st, rk, ct, rcon, rnd, cnt) to 0, with done=0, ready=1.
  - Reset mid-operation aborts the encryption with no done.
  - rst has priority over start on the same edge.

## Timing
- KEY lasts KX_LAT+1 cycles; RND lasts RND_LAT+1 cycles.
- Let N = 10*(KX_LAT+RND_LAT+2). With defaults, N = 50.
- The accept edge is edge 0. done and the new ct appear after edge N. ready goes high after edge N, in the same cycle as done.
- done is high for exactly one cycle.
- A start held high during the done cycle is accepted at edge N+1, giving back-to-back operation with no idle gap beyond that cycle.
- ready falls after the accept edge. busy is implied by ready=0.

## Test plan
- **FIPS-197 C.1**, defaults, bench key and round models attached:
  - key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - ct must be 69c4e0d86a7b0430d8cdb78070b4c55a.
  - done must pulse exactly once, 50 cycles after accept.
- **FIPS-197 B**:
  - key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - ct must be 3925841d02dc09fbdc118597196a0b32.
  - Repeat with KX_LAT=3, RND_LAT=1: same ct, done at 60 cycles.
- **rcon and final flag**:
  - Monitor kx_rcon_o in each KEY state: must read 01,02,04,08,10,20,40,80,1b,36.
  - rnd_final_o must be high only in the 10th RND state.
- **Back-to-back**:
  - Hold start=1 with the B vector, then switch key/pt to the C.1 vector in the cycle after the first accept.
  - First done must give 3925841d…; second done must come at edge 101 and give 69c4e0d8….
- **Reset mid-operation**:
  - Assert rst for 1 cycle at cycle 23 after accept.
  - Required: no done, ready=1 and ct=0 on the next cycle.
  - A following C.1 run completes correctly.
- **Ignored start**:
  - Pulse start with different key/pt at cycle 10 of a busy operation.
  - The result must be unaffected, with only one done.

Source files
------------

// File: rtl/aes_iter_ctrl.sv
// rtl/aes_iter_ctrl.sv - iterative AES-128 round/key sequencer with start/ready/done handshake
module aes_iter_ctrl #(
    parameter int KX_LAT  = 1,
    parameter int RND_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] pt,
    output logic         ready,
    output logic         done,
    output logic [127:0] ct,
    output logic [127:0] kx_key_o,
    output logic [7:0]   kx_rcon_o,
    input  logic [127:0] kx_key_i,
    output logic [127:0] rnd_state_o,
    output logic [127:0] rnd_key_o,
    output logic         rnd_final_o,
    input  logic [127:0] rnd_state_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_KEY  = 2'd1,
        S_RND  = 2'd2
    } state_e;

    // Last count value of each phase; the unit result is sampled on that edge.
    localparam logic [3:0] KX_LAST  = 4'(KX_LAT);
    localparam logic [3:0] RND_LAST = 4'(RND_LAT);
    localparam logic [3:0] LAST_RND = 4'd10;

    state_e        state_q, state_d;
    logic [127:0]  st_q, st_d;
    logic [127:0]  rk_q, rk_d;
    logic [127:0]  ct_q, ct_d;
    logic [7:0]    rcon_q, rcon_d;
    logic [3:0]    rnd_q, rnd_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          final_q, final_d;

    logic          kx_last;
    logic          rnd_last;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Phase-end strobes shared by the FSM and the datapath.
    always_comb begin
        kx_last  = (state_q == S_KEY) && (cnt_q == KX_LAST);
        rnd_last = (state_q == S_RND) && (cnt_q == RND_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_KEY;
            S_KEY:  if (kx_last) state_d = S_RND;
            S_RND:  if (rnd_last) state_d = (rnd_q == LAST_RND) ? S_IDLE : S_KEY;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: ready is the only state-decoded output; the rest are registers.
    always_comb begin
        ready       = (state_q == S_IDLE);
        done        = done_q;
        ct          = ct_q;
        kx_key_o    = rk_q;
        kx_rcon_o   = rcon_q;
        rnd_state_o = st_q;
        rnd_key_o   = rk_q;
        rnd_final_o = final_q;
    end

    // Datapath next-state: load on accept, advance key on KEY end, advance state on RND end.
    // The final flag is registered at the KEY->RND edge so it is high only during round 10's RND phase.
    always_comb begin
        st_d    = st_q;
        rk_d    = rk_q;
        ct_d    = ct_q;
        rcon_d  = rcon_q;
        rnd_d   = rnd_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        final_d = final_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    st_d    = pt ^ key;
                    rk_d    = key;
                    rcon_d  = 8'h01;
                    rnd_d   = 4'd1;
                    cnt_d   = 4'd0;
                    final_d = 1'b0;
                end
            end
            S_KEY: begin
                if (kx_last) begin
                    rk_d    = kx_key_i;
                    rcon_d  = xtime(rcon_q);
                    cnt_d   = 4'd0;
                    final_d = (rnd_q == LAST_RND);
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RND: begin
                if (rnd_last) begin
                    st_d  = rnd_state_i;
                    cnt_d = 4'd0;
                    if (rnd_q != LAST_RND) begin
                        rnd_d = rnd_q + 4'd1;
                    end else begin
                        ct_d   = rnd_state_i;
                        done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                cnt_d = 4'd0;
            end
        endcase
    end

    // Datapath registers; reset clears everything so an aborted run leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= '0;
            rk_q    <= '0;
            ct_q    <= '0;
            rcon_q  <= '0;
            rnd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            final_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            rk_q    <= rk_d;
            ct_q    <= ct_d;
            rcon_q  <= rcon_d;
            rnd_q   <= rnd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            final_q <= final_d;
        end
    end

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// tb/tb_aes_iter_ctrl.sv - scoreboard bench for aes_iter_ctrl with behavioural AES key/round units
module tb_aes_iter_ctrl;

    localparam int KX1 = 1;
    localparam int RD1 = 2;
    localparam int N1  = 10 * (KX1 + RD1 + 2);
    localparam int P1  = KX1 + RD1 + 2;
    localparam int KX2 = 3;
    localparam int RD2 = 1;
    localparam int N2  = 10 * (KX2 + RD2 + 2);

    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic [127:0] ct;
        int           at;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   base = -1;
    exp_t q1[$];
    exp_t q2[$];

    logic [7:0] sbox_t [256];
    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic         start1, start2;
    logic [127:0] key1, pt1, key2, pt2;
    logic         ready1, done1, final1, ready2, done2, final2;
    logic [127:0] ct1, kxk1, kxi1, rs1, rk1, rsi1;
    logic [127:0] ct2, kxk2, kxi2, rs2, rk2, rsi2;
    logic [7:0]   rcon1, rcon2;
    logic [127:0] kp1 [16], rp1 [16], kp2 [16], rp2 [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_iter_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start1), .key(key1), .pt(pt1),
        .ready(ready1), .done(done1), .ct(ct1),
        .kx_key_o(kxk1), .kx_rcon_o(rcon1), .kx_key_i(kxi1),
        .rnd_state_o(rs1), .rnd_key_o(rk1), .rnd_final_o(final1), .rnd_state_i(rsi1)
    );

    aes_iter_ctrl #(.KX_LAT(KX2), .RND_LAT(RD2)) u_dut_alt (
        .clk(clk), .rst(rst), .start(start2), .key(key2), .pt(pt2),
        .ready(ready2), .done(done2), .ct(ct2),
        .kx_key_o(kxk2), .kx_rcon_o(rcon2), .kx_key_i(kxi2),
        .rnd_state_o(rs2), .rnd_key_o(rk2), .rnd_final_o(final2), .rnd_state_i(rsi2)
    );

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {w3[23:0], w3[31:24]};
        t  = {sbox_t[t[31:24]] ^ rc, sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [7:0] b [16];
        logic [7:0] sr [16];
        logic [7:0] m [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c+r] = b[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            if (fin) begin
                for (int r = 0; r < 4; r++) m[4*c+r] = sr[4*c+r];
            end else begin
                m[4*c+0] = xt(sr[4*c]) ^ gmul(sr[4*c+1], 8'h03) ^ sr[4*c+2] ^ sr[4*c+3];
                m[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ gmul(sr[4*c+2], 8'h03) ^ sr[4*c+3];
                m[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ gmul(sr[4*c+3], 8'h03);
                m[4*c+3] = gmul(sr[4*c], 8'h03) ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = m[i];
        return res ^ k;
    endfunction

    // S-box built from the GF(2^8) inverse (x^254) followed by the affine map.
    initial begin
        for (int v = 0; v < 256; v++) begin
            logic [7:0] a, inv, s;
            a = 8'(v);
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, a);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[v] = s;
        end
    end

    // Free-running unit models: compute on the presented inputs, then delay through a shift register.
    always @(posedge clk) begin
        kp1[0] <= kexp(kxk1, rcon1);
        rp1[0] <= aes_round(rs1, rk1, final1);
        kp2[0] <= kexp(kxk2, rcon2);
        rp2[0] <= aes_round(rs2, rk2, final2);
        for (int i = 1; i < 16; i++) begin
            kp1[i] <= kp1[i-1];
            rp1[i] <= rp1[i-1];
            kp2[i] <= kp2[i-1];
            rp2[i] <= rp2[i-1];
        end
    end
    assign kxi1 = kp1[KX1-1];
    assign rsi1 = rp1[RD1-1];
    assign kxi2 = kp2[KX2-1];
    assign rsi2 = rp2[RD2-1];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Monitor: scoreboard pops on done, per-cycle rcon/final/ready tracking of the tracked run.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (done1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("ct", ct1, e.ct);
                    chk("done_cycle", 128'(cyc), 128'(e.at));
                    chk("ready_with_done", ready1, 1'b1);
                end
            end
            if (done2) begin
                if (q2.size() == 0) begin
                    chk("unexpected_done_alt", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = q2.pop_front();
                    chk("ct_alt", ct2, e.ct);
                    chk("done_cycle_alt", 128'(cyc), 128'(e.at));
                end
            end
            if (base >= 0 && cyc >= base && cyc < base + N1) begin
                int t, r, p;
                t = cyc - base;
                r = t / P1;
                p = t % P1;
                chk("busy", ready1, 1'b0);
                if (p <= KX1) chk("rcon", rcon1, rcon_tab[r]);
                chk("final", final1, (p > KX1) && (r == 9));
            end
        end
    end

    task automatic run1(input logic [127:0] k, input logic [127:0] p, input logic [127:0] c);
        start1 = 1'b1; key1 = k; pt1 = p;
        q1.push_back('{c, cyc + 1 + N1});
        base = cyc + 1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic drain(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (q1.size() == 0 && q2.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_q1", 128'(q1.size()), 128'd0);
        chk("drain_q2", 128'(q2.size()), 128'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        rst = 1'b1;
        start1 = 1'b0; key1 = '0; pt1 = '0;
        start2 = 1'b0; key2 = '0; pt2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready1, 1'b1);
        chk("rst_done", done1, 1'b0);
        chk("rst_ct", ct1, 128'd0);
        chk("rst_rcon", rcon1, 8'h00);
        chk("rst_state", rs1, 128'd0);
        chk("rst_ready_alt", ready2, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        run1(KC, PC, CC);
        drain(200);
        run1(KB, PB, CB);
        drain(200);

        start2 = 1'b1; key2 = KB; pt2 = PB;
        q2.push_back('{CB, cyc + 1 + N2});
        @(negedge clk);
        start2 = 1'b0;
        drain(200);

        // Back-to-back: start held, vector switched right after the first accept.
        a = cyc + 1;
        start1 = 1'b1; key1 = KB; pt1 = PB;
        q1.push_back('{CB, a + N1});
        q1.push_back('{CC, a + 2 * N1 + 1});
        base = a;
        @(negedge clk);
        key1 = KC; pt1 = PC;
        while (cyc < a + N1) @(negedge clk);
        base = cyc + 1;
        @(negedge clk);
        start1 = 1'b0;
        drain(200);

        // Abort mid-operation: reset hits at edge 23 after accept.
        a = cyc + 1;
        start1 = 1'b1; key1 = KC; pt1 = PC;
        base = a;
        @(negedge clk);
        start1 = 1'b0;
        while (cyc < a + 22) @(negedge clk);
        rst = 1'b1;
        base = -1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", ready1, 1'b1);
        chk("abort_ct", ct1, 128'd0);
        chk("abort_done", done1, 1'b0);
        repeat (N1 + 10) @(negedge clk);
        run1(KC, PC, CC);
        drain(200);

        // Start pulsed while busy must be ignored.
        a = cyc + 1;
        run1(KC, PC, CC);
        while (cyc < a + 10) @(negedge clk);
        start1 = 1'b1; key1 = KB; pt1 = PB;
        @(negedge clk);
        start1 = 1'b0;
        drain(200);
        repeat (N1 + 10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
